// File: rtl/bitslip_align_ctrl.sv
// Word-alignment training controller for one LVDS lane: slips the lane's bitslip
// muxer until the training pattern is seen MATCH_COUNT times in a row, or gives up.
module bitslip_align_ctrl #(
  parameter int                   DATAWIDTH     = 10,
  parameter logic [DATAWIDTH-1:0] TRAINPATTERN  = 10'h3A6,
  parameter int                   SETTLE_CYCLES = 4,
  parameter int                   MATCH_COUNT   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] din,
  output logic                 bitslip,
  output logic                 busy,
  output logic                 locked,
  output logic                 fail,
  output logic [3:0]           slip_count
);

  localparam int WAIT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]        MATCH_LAST = 8'(MATCH_COUNT - 1);
  localparam logic [3:0]        SLIP_LAST  = 4'(DATAWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [7:0]        match_cnt_reg;

  // Outputs are updated together with the state so they always reflect it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      slip_count    <= '0;
      bitslip       <= 1'b0;
      busy          <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state_reg)
        IDLE, LOCKED, FAIL: begin
          // The current muxer rotation is the first candidate; no muxer reset.
          if (start) begin
            state_reg    <= SETTLE;
            wait_cnt_reg <= '0;
            slip_count   <= '0;
            busy         <= 1'b1;
            locked       <= 1'b0;
            fail         <= 1'b0;
          end
        end
        SETTLE: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg     <= CHECK;
            match_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        CHECK: begin
          if (din == TRAINPATTERN) begin
            match_cnt_reg <= match_cnt_reg + 1'b1;
            if (match_cnt_reg == MATCH_LAST) begin
              state_reg <= LOCKED;
              busy      <= 1'b0;
              locked    <= 1'b1;
            end
          end else if (slip_count == SLIP_LAST) begin
            // One more slip would return to the starting rotation.
            state_reg     <= FAIL;
            match_cnt_reg <= '0;
            busy          <= 1'b0;
            fail          <= 1'b1;
          end else begin
            state_reg     <= SLIP;
            match_cnt_reg <= '0;
            bitslip       <= 1'b1;
          end
        end
        SLIP: begin
          state_reg    <= SETTLE;
          wait_cnt_reg <= '0;
          slip_count   <= slip_count + 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          locked    <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Directed bench for bitslip_align_ctrl with a simple rotating-muxer lane model.
module tb_bitslip_align_ctrl;

  localparam int         DW  = 10;
  localparam logic [9:0] PAT = 10'h3A6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] din = '0;
  logic       bitslip, busy, locked, fail;
  logic [3:0] slip_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;
  int min_gap = 1000;
  int rot = 0;
  int mis = 0;
  bit mux_mode = 1'b0;
  int dc;

  always #5 clk = ~clk;

  bitslip_align_ctrl #(
    .DATAWIDTH(10),
    .TRAINPATTERN(10'h3A6),
    .SETTLE_CYCLES(4),
    .MATCH_COUNT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .din(din),
    .bitslip(bitslip),
    .busy(busy),
    .locked(locked),
    .fail(fail),
    .slip_count(slip_count)
  );

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  // One clock; observe just after the edge and let the lane model react to bitslip.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip === 1'b1) begin
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      pulses++;
      rot = (rot + 1) % DW;
    end
    if (mux_mode) din = rotl(PAT, (mis + rot) % DW);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc = 0;
    pulses = 0;
    last_pulse = -1;
    min_gap = 1000;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      step();
      if (locked === 1'b1 || fail === 1'b1) done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bitslip, busy, locked, fail} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000", {bitslip, busy, locked, fail});
    end
    tests++;
    if (slip_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_slip_count: got %0d expected 0", slip_count);
    end
    reset_n = 1'b1;
    repeat (3) step();
    tests++;
    if ({bitslip, busy, locked, fail} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b expected 0000", {bitslip, busy, locked, fail});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_aligned();
    mux_mode = 1'b1;
    mis = 0;
    rot = 0;
    din = PAT;
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL aligned_busy_c1: got %b expected 1", busy);
    end
    while (cyc < 20) step();
    tests++;
    if ({locked, busy} !== 2'b01) begin
      fails++;
      $display("FAIL aligned_c20: got locked,busy=%b expected 01", {locked, busy});
    end
    step();
    tests++;
    if ({locked, busy} !== 2'b10) begin
      fails++;
      $display("FAIL aligned_c21: got locked,busy=%b expected 10", {locked, busy});
    end
    tests++;
    if (slip_count !== 4'd0 || pulses != 0) begin
      fails++;
      $display("FAIL aligned_slips: got slip_count=%0d pulses=%0d expected 0 0", slip_count, pulses);
    end
    $display("[TB] test_aligned done cycle=%0d", cyc);
  endtask

  task automatic test_offset3();
    mux_mode = 1'b1;
    mis = 7;
    rot = 0;
    din = rotl(PAT, 7);
    pulse_start();
    run_until_done(200, dc);
    tests++;
    if (dc != 39 || locked !== 1'b1) begin
      fails++;
      $display("FAIL offset3_lock: got cycle=%0d locked=%b expected 39 1", dc, locked);
    end
    tests++;
    if (slip_count !== 4'd3 || pulses != 3) begin
      fails++;
      $display("FAIL offset3_slips: got slip_count=%0d pulses=%0d expected 3 3", slip_count, pulses);
    end
    tests++;
    if (min_gap < 6) begin
      fails++;
      $display("FAIL offset3_gap: got %0d expected >=6", min_gap);
    end
    $display("[TB] test_offset3 done cycle=%0d", dc);
  endtask

  task automatic test_retrain();
    pulse_start();
    tests++;
    if ({busy, locked} !== 2'b10 || slip_count !== 4'd0) begin
      fails++;
      $display("FAIL retrain_c1: got busy,locked=%b slip_count=%0d expected 10 0", {busy, locked}, slip_count);
    end
    while (cyc < 8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(100, dc);
    tests++;
    if (dc != 21 || locked !== 1'b1 || pulses != 0) begin
      fails++;
      $display("FAIL retrain_lock: got cycle=%0d locked=%b pulses=%0d expected 21 1 0", dc, locked, pulses);
    end
    $display("[TB] test_retrain done cycle=%0d", dc);
  endtask

  task automatic test_glitch();
    mux_mode = 1'b0;
    din = PAT;
    pulse_start();
    dc = -1;
    for (int i = 0; i < 100 && dc < 0; i++) begin
      step();
      din = (cyc == 15) ? (PAT ^ 10'h001) : PAT;
      if (locked === 1'b1 || fail === 1'b1) dc = cyc;
    end
    tests++;
    if (dc != 37 || locked !== 1'b1) begin
      fails++;
      $display("FAIL glitch_lock: got cycle=%0d locked=%b expected 37 1", dc, locked);
    end
    tests++;
    if (pulses != 1 || last_pulse != 16 || slip_count !== 4'd1) begin
      fails++;
      $display("FAIL glitch_slip: got pulses=%0d at=%0d slip_count=%0d expected 1 16 1", pulses, last_pulse, slip_count);
    end
    $display("[TB] test_glitch done cycle=%0d", dc);
  endtask

  task automatic test_absent();
    mux_mode = 1'b0;
    din = 10'h000;
    pulse_start();
    run_until_done(200, dc);
    tests++;
    if (dc != 60 || {fail, locked} !== 2'b10) begin
      fails++;
      $display("FAIL absent_fail: got cycle=%0d fail,locked=%b expected 60 10", dc, {fail, locked});
    end
    tests++;
    if (slip_count !== 4'd9 || pulses != 9 || min_gap < 6) begin
      fails++;
      $display("FAIL absent_slips: got slip_count=%0d pulses=%0d gap=%0d expected 9 9 >=6", slip_count, pulses, min_gap);
    end
    repeat (20) step();
    tests++;
    if (pulses != 9 || fail !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL absent_hold: got pulses=%0d fail=%b busy=%b expected 9 1 0", pulses, fail, busy);
    end
    $display("[TB] test_absent done cycle=%0d", dc);
  endtask

  task automatic test_async_reset();
    mux_mode = 1'b0;
    din = 10'h000;
    pulse_start();
    for (int i = 0; i < 20 && bitslip !== 1'b1; i++) step();
    tests++;
    if (cyc != 6 || bitslip !== 1'b1) begin
      fails++;
      $display("FAIL areset_slip_cycle: got cycle=%0d bitslip=%b expected 6 1", cyc, bitslip);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({bitslip, busy, locked, fail} !== 4'b0000) begin
      fails++;
      $display("FAIL areset_async: got %b expected 0000", {bitslip, busy, locked, fail});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) step();
    tests++;
    if ({bitslip, busy, locked, fail} !== 4'b0000 || slip_count !== 4'd0) begin
      fails++;
      $display("FAIL areset_idle: got flags=%b slip_count=%0d expected 0000 0", {bitslip, busy, locked, fail}, slip_count);
    end
    din = PAT;
    pulse_start();
    run_until_done(100, dc);
    tests++;
    if (dc != 21 || locked !== 1'b1) begin
      fails++;
      $display("FAIL areset_relock: got cycle=%0d locked=%b expected 21 1", dc, locked);
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset3();
    test_retrain();
    test_glitch();
    test_absent();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
